// File: rtl/reg_bus_stat_endpoint.sv
// OCL register-bus responder: control/status/scratch registers plus four 64-bit
// event counters read through a shared LSB-triggered upper-word snapshot.
module reg_bus_stat_endpoint #(
   parameter logic [31:0] BLOCK_ID   = 32'd0,
   parameter logic [31:0] CTRL_RESET = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_bus_wvalid,
   input  logic [15:0] reg_bus_waddr,
   input  logic [31:0] reg_bus_wdata,
   input  logic        reg_bus_arvalid,
   input  logic [15:0] reg_bus_araddr,
   output logic        reg_bus_rvalid,
   output logic [31:0] reg_bus_rdata,
   input  logic        evt_start,
   input  logic        evt_commit,
   input  logic        evt_abort,
   output logic        count_enable
);

   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_CLEAR    = 8'h04;
   localparam logic [7:0] ADDR_STATUS   = 8'h08;
   localparam logic [7:0] ADDR_CYC_L    = 8'h10;
   localparam logic [7:0] ADDR_CYC_H    = 8'h14;
   localparam logic [7:0] ADDR_START_L  = 8'h18;
   localparam logic [7:0] ADDR_START_H  = 8'h1C;
   localparam logic [7:0] ADDR_COMMIT_L = 8'h20;
   localparam logic [7:0] ADDR_COMMIT_H = 8'h24;
   localparam logic [7:0] ADDR_ABORT_L  = 8'h28;
   localparam logic [7:0] ADDR_ABORT_H  = 8'h2C;
   localparam logic [7:0] ADDR_SCRATCH  = 8'h30;
   localparam logic [7:0] ADDR_ID       = 8'h34;
   localparam logic [31:0] UNMAPPED     = 32'hDEAD_BEEF;

   logic [1:0]  ctrl_q, ctrl_d;
   logic [31:0] scratch_q, scratch_d;
   logic        ovf_q, ovf_d;
   logic [31:0] shadow_q, shadow_d;
   logic [63:0] cyc_q, cyc_d;
   logic [63:0] start_q, start_d;
   logic [63:0] commit_q, commit_d;
   logic [63:0] abort_q, abort_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   logic [7:0]  wr_addr, rd_addr;
   logic        wr_ctrl, wr_clear, wr_status, wr_scratch;
   logic        run;
   logic        inc_start, inc_commit, inc_abort;
   logic        wrap_any;
   logic [31:0] rd_word;
   logic        rd_is_lsb;
   logic [31:0] rd_upper;
   logic        unused_addr_hi;

   assign wr_addr = reg_bus_waddr[7:0];
   assign rd_addr = reg_bus_araddr[7:0];
   assign unused_addr_hi = ^{reg_bus_waddr[15:8], reg_bus_araddr[15:8]};

   assign wr_ctrl    = reg_bus_wvalid && (wr_addr == ADDR_CTRL);
   assign wr_clear   = reg_bus_wvalid && (wr_addr == ADDR_CLEAR);
   assign wr_status  = reg_bus_wvalid && (wr_addr == ADDR_STATUS);
   assign wr_scratch = reg_bus_wvalid && (wr_addr == ADDR_SCRATCH);

   // Counters run only when enabled and not frozen; events outside that window are lost.
   assign run        = ctrl_q[0] & ~ctrl_q[1];
   assign inc_start  = run & evt_start;
   assign inc_commit = run & evt_commit;
   assign inc_abort  = run & evt_abort;

   always_comb begin
      cyc_d    = cyc_q + {63'd0, run};
      start_d  = start_q + {63'd0, inc_start};
      commit_d = commit_q + {63'd0, inc_commit};
      abort_d  = abort_q + {63'd0, inc_abort};
      wrap_any = (run & (&cyc_q)) | (inc_start & (&start_q)) |
                 (inc_commit & (&commit_q)) | (inc_abort & (&abort_q));
      if (wr_clear) begin
         cyc_d    = '0;
         start_d  = '0;
         commit_d = '0;
         abort_d  = '0;
         wrap_any = 1'b0;
      end
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      scratch_d = scratch_q;
      if (wr_ctrl) begin
         ctrl_d = reg_bus_wdata[1:0];
      end
      if (wr_scratch) begin
         scratch_d = reg_bus_wdata;
      end
      // A wrap in the same cycle as the W1C write must leave the flag set.
      ovf_d = (ovf_q & ~(wr_status & reg_bus_wdata[0])) | wrap_any;
   end

   // Read decode samples pre-write state, so a same-cycle write is not visible.
   always_comb begin
      rd_word   = UNMAPPED;
      rd_is_lsb = 1'b0;
      rd_upper  = '0;
      case (rd_addr)
         ADDR_CTRL:     rd_word = {30'd0, ctrl_q};
         ADDR_CLEAR:    rd_word = '0;
         ADDR_STATUS:   rd_word = {31'd0, ovf_q};
         ADDR_CYC_L: begin
            rd_word   = cyc_q[31:0];
            rd_is_lsb = 1'b1;
            rd_upper  = cyc_q[63:32];
         end
         ADDR_START_L: begin
            rd_word   = start_q[31:0];
            rd_is_lsb = 1'b1;
            rd_upper  = start_q[63:32];
         end
         ADDR_COMMIT_L: begin
            rd_word   = commit_q[31:0];
            rd_is_lsb = 1'b1;
            rd_upper  = commit_q[63:32];
         end
         ADDR_ABORT_L: begin
            rd_word   = abort_q[31:0];
            rd_is_lsb = 1'b1;
            rd_upper  = abort_q[63:32];
         end
         ADDR_CYC_H,
         ADDR_START_H,
         ADDR_COMMIT_H,
         ADDR_ABORT_H:  rd_word = shadow_q;
         ADDR_SCRATCH:  rd_word = scratch_q;
         ADDR_ID:       rd_word = BLOCK_ID;
         default:       rd_word = UNMAPPED;
      endcase
   end

   always_comb begin
      rvalid_d = reg_bus_arvalid;
      rdata_d  = reg_bus_arvalid ? rd_word : rdata_q;
      shadow_d = shadow_q;
      if (wr_clear) begin
         shadow_d = '0;
      end else if (reg_bus_arvalid && rd_is_lsb) begin
         shadow_d = rd_upper;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= CTRL_RESET[1:0];
         scratch_q <= '0;
         ovf_q     <= 1'b0;
         shadow_q  <= '0;
         cyc_q     <= '0;
         start_q   <= '0;
         commit_q  <= '0;
         abort_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         scratch_q <= scratch_d;
         ovf_q     <= ovf_d;
         shadow_q  <= shadow_d;
         cyc_q     <= cyc_d;
         start_q   <= start_d;
         commit_q  <= commit_d;
         abort_q   <= abort_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // A response whose cycle overlaps reset is suppressed so the bridge never sees it.
   assign reg_bus_rvalid = rvalid_q & ~rst;
   assign reg_bus_rdata  = rdata_q;
   assign count_enable   = ctrl_q[0];

endmodule

// File: tb/tb_reg_bus_stat_endpoint.sv
// Directed bench for reg_bus_stat_endpoint with immediate-assertion checks.
module tb_reg_bus_stat_endpoint;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_bus_wvalid;
   logic [15:0] reg_bus_waddr;
   logic [31:0] reg_bus_wdata;
   logic        reg_bus_arvalid;
   logic [15:0] reg_bus_araddr;
   logic        reg_bus_rvalid;
   logic [31:0] reg_bus_rdata;
   logic        evt_start;
   logic        evt_commit;
   logic        evt_abort;
   logic        count_enable;

   int total = 0;
   int bad   = 0;
   int rv_cnt;

   reg_bus_stat_endpoint #(.BLOCK_ID(32'd5), .CTRL_RESET(32'h1)) dut (
      .clk(clk),
      .rst(rst),
      .reg_bus_wvalid(reg_bus_wvalid),
      .reg_bus_waddr(reg_bus_waddr),
      .reg_bus_wdata(reg_bus_wdata),
      .reg_bus_arvalid(reg_bus_arvalid),
      .reg_bus_araddr(reg_bus_araddr),
      .reg_bus_rvalid(reg_bus_rvalid),
      .reg_bus_rdata(reg_bus_rdata),
      .evt_start(evt_start),
      .evt_commit(evt_commit),
      .evt_abort(evt_abort),
      .count_enable(count_enable)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      reg_bus_waddr  = {8'hC3, a};
      reg_bus_wdata  = d;
      reg_bus_wvalid = 1'b1;
      next_cycle();
      reg_bus_wvalid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
      reg_bus_araddr  = {8'h5A, a};
      reg_bus_arvalid = 1'b1;
      @(negedge clk);
      chk({tag, "_idle"}, {31'd0, reg_bus_rvalid}, 32'd0);
      next_cycle();
      reg_bus_arvalid = 1'b0;
      @(negedge clk);
      chk({tag, "_vld"}, {31'd0, reg_bus_rvalid}, 32'd1);
      chk(tag, reg_bus_rdata, exp);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b1;
      reg_bus_wvalid = 1'b0;
      reg_bus_waddr = '0;
      reg_bus_wdata = '0;
      reg_bus_arvalid = 1'b1;
      reg_bus_araddr = 16'h0000;
      evt_start = 1'b0;
      evt_commit = 1'b0;
      evt_abort = 1'b0;

      // reset: strobes during rst must never produce a response
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_rvalid", {31'd0, reg_bus_rvalid}, 32'd0);
      end
      chk("rst_rdata", reg_bus_rdata, 32'd0);
      chk("rst_cen", {31'd0, count_enable}, 32'd1);
      next_cycle();
      rst = 1'b0;
      reg_bus_arvalid = 1'b0;
      @(negedge clk);
      chk("rst_resp_drop", {31'd0, reg_bus_rvalid}, 32'd0);
      next_cycle();

      rd(8'h00, 32'h1, "ctrl_reset");
      rd(8'h34, 32'h5, "id");

      // scratch, unmapped, RO write, clear read, hold of rdata
      wr(8'h30, 32'hA5A5_1234);
      rd(8'h30, 32'hA5A5_1234, "scratch");
      rd(8'h3C, 32'hDEAD_BEEF, "unmapped");
      @(negedge clk);
      chk("rdata_hold", reg_bus_rdata, 32'hDEAD_BEEF);
      next_cycle();
      wr(8'h34, 32'h0000_1234);
      rd(8'h34, 32'h5, "id_ro");
      rd(8'h04, 32'h0, "clear_rd");

      // same-cycle write and read of scratch returns the old value
      reg_bus_waddr = 16'h0030;
      reg_bus_wdata = 32'h0BAD_F00D;
      reg_bus_wvalid = 1'b1;
      reg_bus_araddr = 16'h0030;
      reg_bus_arvalid = 1'b1;
      next_cycle();
      reg_bus_wvalid = 1'b0;
      reg_bus_arvalid = 1'b0;
      @(negedge clk);
      chk("rw_same_vld", {31'd0, reg_bus_rvalid}, 32'd1);
      chk("rw_same_old", reg_bus_rdata, 32'hA5A5_1234);
      next_cycle();
      rd(8'h30, 32'h0BAD_F00D, "rw_same_new");

      // start counting, freeze, disable, clear-vs-event
      wr(8'h04, 32'h0);
      evt_start = 1'b1;
      repeat (7) next_cycle();
      evt_start = 1'b0;
      wr(8'h00, 32'h3);
      @(negedge clk);
      chk("cen_frozen", {31'd0, count_enable}, 32'd1);
      next_cycle();
      evt_start = 1'b1;
      repeat (3) next_cycle();
      evt_start = 1'b0;
      rd(8'h18, 32'd7, "start_lsb");
      rd(8'h1C, 32'd0, "start_msb");
      wr(8'h00, 32'h0);
      @(negedge clk);
      chk("cen_off", {31'd0, count_enable}, 32'd0);
      next_cycle();
      evt_start = 1'b1;
      repeat (2) next_cycle();
      evt_start = 1'b0;
      wr(8'h00, 32'h1);
      rd(8'h18, 32'd7, "start_disabled");
      evt_start = 1'b1;
      wr(8'h04, 32'h0);
      evt_start = 1'b0;
      rd(8'h18, 32'd0, "clear_wins");

      // snapshot coherence across the 32-bit carry
      force dut.start_q = 64'h0000_0000_FFFF_FFFF;
      next_cycle();
      release dut.start_q;
      rd(8'h18, 32'hFFFF_FFFF, "snap_lsb");
      evt_start = 1'b1;
      next_cycle();
      evt_start = 1'b0;
      rd(8'h1C, 32'h0, "snap_msb_shadow");
      rd(8'h18, 32'h0, "snap_lsb2");
      rd(8'h1C, 32'h1, "snap_msb2");

      // 64-bit wrap and sticky overflow
      force dut.commit_q = 64'hFFFF_FFFF_FFFF_FFFF;
      next_cycle();
      release dut.commit_q;
      evt_commit = 1'b1;
      next_cycle();
      evt_commit = 1'b0;
      rd(8'h20, 32'h0, "commit_wrap_lsb");
      rd(8'h24, 32'h0, "commit_wrap_msb");
      rd(8'h08, 32'h1, "ovf_set");
      wr(8'h08, 32'h1);
      rd(8'h08, 32'h0, "ovf_w1c");
      force dut.commit_q = 64'hFFFF_FFFF_FFFF_FFFF;
      next_cycle();
      release dut.commit_q;
      evt_commit = 1'b1;
      wr(8'h08, 32'h1);
      evt_commit = 1'b0;
      rd(8'h08, 32'h1, "ovf_set_beats_clr");

      // freeze CYCLES at 1: clear while running, then disable next cycle
      wr(8'h04, 32'h0);
      wr(8'h00, 32'h0);

      // four back-to-back reads
      reg_bus_araddr = 16'h0010;
      reg_bus_arvalid = 1'b1;
      @(negedge clk);
      chk("b2b_idle", {31'd0, reg_bus_rvalid}, 32'd0);
      next_cycle();
      reg_bus_araddr = 16'h0014;
      @(negedge clk);
      chk("b2b0_vld", {31'd0, reg_bus_rvalid}, 32'd1);
      chk("b2b0_cyc_lsb", reg_bus_rdata, 32'd1);
      next_cycle();
      reg_bus_araddr = 16'h0030;
      @(negedge clk);
      chk("b2b1_vld", {31'd0, reg_bus_rvalid}, 32'd1);
      chk("b2b1_cyc_msb", reg_bus_rdata, 32'd0);
      next_cycle();
      reg_bus_araddr = 16'h0008;
      @(negedge clk);
      chk("b2b2_vld", {31'd0, reg_bus_rvalid}, 32'd1);
      chk("b2b2_scratch", reg_bus_rdata, 32'h0BAD_F00D);
      next_cycle();
      reg_bus_arvalid = 1'b0;
      @(negedge clk);
      chk("b2b3_vld", {31'd0, reg_bus_rvalid}, 32'd1);
      chk("b2b3_status", reg_bus_rdata, 32'h1);
      next_cycle();
      @(negedge clk);
      chk("b2b_end", {31'd0, reg_bus_rvalid}, 32'd0);
      next_cycle();

      // reset in the middle of a read burst
      rv_cnt = 0;
      reg_bus_araddr = 16'h0010;
      reg_bus_arvalid = 1'b1;
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      next_cycle();
      reg_bus_araddr = 16'h0014;
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      chk("rstb_first", reg_bus_rdata, 32'd1);
      next_cycle();
      reg_bus_araddr = 16'h0030;
      rst = 1'b1;
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      chk("rstb_resp_cut", {31'd0, reg_bus_rvalid}, 32'd0);
      next_cycle();
      reg_bus_araddr = 16'h0008;
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      chk("rstb_rdata", reg_bus_rdata, 32'd0);
      chk("rstb_cen", {31'd0, count_enable}, 32'd1);
      next_cycle();
      rst = 1'b0;
      reg_bus_arvalid = 1'b0;
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      next_cycle();
      @(negedge clk);
      rv_cnt += int'(reg_bus_rvalid);
      chk("rstb_rvalid_count", rv_cnt, 32'd1);
      next_cycle();
      rd(8'h30, 32'h0, "rstb_scratch");
      rd(8'h00, 32'h1, "rstb_ctrl");
      rd(8'h08, 32'h0, "rstb_status");
      rd(8'h2C, 32'h0, "rstb_shadow");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
